// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared I2C types and constants for the master and target blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } i2c_slv_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Master command encodings
    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
// Module      : i2c_line_sync
// Description : 2-FF synchronizer with registered previous value for edges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_line_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic       r_prev;

    // Reset to the idle bus level so release of reset cannot fake a condition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {2{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_prev <= r_sync[1];
        end
    end

    assign o_level = r_sync[1];
    assign o_rise  = r_sync[1] & ~r_prev;
    assign o_fall  = ~r_sync[1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ============================================================================
// Module      : i2c_slave
// Description : Single 7-bit address I2C target with host tick/request strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h42,
    parameter int         HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    input  logic       rx_ack_en,
    output logic [7:0] rx_data,
    output logic       rx_tick,
    output logic       tx_req,
    output logic       start_tick,
    output logic       stop_tick,
    output logic       busy,
    output logic       addr_rw
);

    localparam int c_CNT_W = $clog2(HOLD + 1);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_slv_state_t r_state, w_state_nxt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_tick, r_tx_req, r_start_tick, r_stop_tick;
    logic               r_busy, r_addr_rw;
    logic               r_sda_low, r_drv_pend;
    logic [c_CNT_W-1:0] r_hold_cnt;

    logic w_cnt_clr, w_cnt_inc, w_shift_in, w_shift_out, w_load_tx;
    logic w_rx_upd, w_tx_req, w_busy_set, w_busy_clr;
    logic w_release, w_sched, w_drv_val;

    i2c_line_sync u_scl_sync (
        .clk(clk), .reset(reset), .i_line(scl),
        .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk(clk), .reset(reset), .i_line(sda),
        .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // w_drv_val = 1 means pull SDA low once the hold delay expires
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_shift_in  = 1'b0;
        w_shift_out = 1'b0;
        w_load_tx   = 1'b0;
        w_rx_upd    = 1'b0;
        w_tx_req    = 1'b0;
        w_busy_set  = 1'b0;
        w_busy_clr  = 1'b0;
        w_release   = 1'b0;
        w_sched     = 1'b0;
        w_drv_val   = 1'b0;
        if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_clr   = 1'b1;
            w_release   = 1'b1;
            w_busy_clr  = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
            w_busy_clr  = 1'b1;
        end else begin
            w_sched = w_scl_fall;
            case (r_state)
                S_ADDR: begin
                    w_shift_in = w_scl_rise;
                    // The first fall after START carries no bit, so 8 bits end at count 8
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            if (r_shift[7:1] == ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_cnt_clr   = 1'b1;
                                w_busy_set  = 1'b1;
                                w_drv_val   = 1'b1;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    w_tx_req = w_scl_rise & r_addr_rw;
                    if (w_scl_fall) begin
                        w_cnt_clr = 1'b1;
                        if (r_addr_rw) begin
                            w_load_tx   = 1'b1;
                            w_drv_val   = ~tx_data[7];
                            w_state_nxt = S_RD_DATA;
                        end else begin
                            w_state_nxt = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    w_shift_in = w_scl_rise;
                    w_rx_upd   = w_scl_rise & (r_bit_cnt == 4'd7);
                    if (w_scl_fall) begin
                        w_cnt_inc = 1'b1;
                        if (r_bit_cnt == 4'd7) begin
                            w_state_nxt = S_WR_ACK;
                            w_drv_val   = rx_ack_en;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_fall) begin
                        w_cnt_inc = 1'b1;
                        if (r_bit_cnt == 4'd7) begin
                            w_state_nxt = S_RD_ACK;
                        end else begin
                            w_shift_out = 1'b1;
                            w_drv_val   = ~r_shift[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda_lvl == I2C_ACK) w_tx_req    = 1'b1;
                        else                      w_state_nxt = S_IGNORE;
                    end
                    if (w_scl_fall) begin
                        w_load_tx   = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_drv_val   = ~tx_data[7];
                        w_state_nxt = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_tick    <= 1'b0;
            r_tx_req     <= 1'b0;
            r_start_tick <= 1'b0;
            r_stop_tick  <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_rw    <= 1'b0;
            r_sda_low    <= 1'b0;
            r_drv_pend   <= 1'b0;
            r_hold_cnt   <= '0;
        end else begin
            r_rx_tick    <= w_rx_upd;
            r_tx_req     <= w_tx_req;
            r_start_tick <= w_start;
            r_stop_tick  <= w_stop;

            if (w_cnt_clr)      r_bit_cnt <= 4'd0;
            else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 4'd1;

            if (w_load_tx)        r_shift <= tx_data;
            else if (w_shift_in)  r_shift <= {r_shift[6:0], w_sda_lvl};
            else if (w_shift_out) r_shift <= {r_shift[6:0], 1'b0};

            if (w_rx_upd) r_rx_data <= {r_shift[6:0], w_sda_lvl};

            if (w_busy_set) begin
                r_busy    <= 1'b1;
                r_addr_rw <= r_shift[0];
            end else if (w_busy_clr) begin
                r_busy <= 1'b0;
            end

            if (w_release) begin
                r_sda_low  <= 1'b0;
                r_hold_cnt <= '0;
            end else if (w_sched) begin
                r_hold_cnt <= c_CNT_W'(HOLD);
                r_drv_pend <= w_drv_val;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - c_CNT_W'(1);
                if (r_hold_cnt == c_CNT_W'(1)) r_sda_low <= r_drv_pend;
            end
        end
    end

    assign sda        = r_sda_low ? 1'b0 : 1'bz;
    assign rx_data    = r_rx_data;
    assign rx_tick    = r_rx_tick;
    assign tx_req     = r_tx_req;
    assign start_tick = r_start_tick;
    assign stop_tick  = r_stop_tick;
    assign busy       = r_busy;
    assign addr_rw    = r_addr_rw;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ============================================================================
// Module      : tb_i2c_slave
// Description : Self-checking bench: bus master model, host model, ref model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_slave;

    typedef struct {
        logic [7:0] addr;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack_en;
        int         dvsr;
        logic       e_aack;
        logic       e_dack;
        logic [7:0] e_r0;
        logic [7:0] e_r1;
        logic [7:0] e_rx;
        int         e_ticks;
        int         e_req;
        logic       e_busy;
        logic       e_rw;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       rx_ack_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    wire  [7:0] rx_data;
    wire        rx_tick, tx_req, start_tick, stop_tick, busy, addr_rw;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.ADDR(7'h42), .HOLD(4)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .tx_data(tx_data), .rx_ack_en(rx_ack_en), .rx_data(rx_data),
        .rx_tick(rx_tick), .tx_req(tx_req), .start_tick(start_tick),
        .stop_tick(stop_tick), .busy(busy), .addr_rw(addr_rw)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int q      = 25;
    int cnt_rx = 0, cnt_req = 0, cnt_start = 0, cnt_stop = 0, cnt_drv = 0;
    logic [7:0] tx_q[$];
    vec_t tbl[6];

    // Host + bus monitor: answers tx_req from the queue and counts strobes
    initial forever begin
        @(negedge clk);
        if (rx_tick)    cnt_rx++;
        if (start_tick) cnt_start++;
        if (stop_tick)  cnt_stop++;
        if (!m_sda_low && sda === 1'b0) cnt_drv++;
        if (tx_req) begin
            cnt_req++;
            tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit after %0d checks", n_chk);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic qw;
        repeat (q) @(posedge clk);
    endtask

    task automatic m_start;
        m_sda_low = 1'b0; qw;
        scl = 1'b1;       qw;
        m_sda_low = 1'b1; qw;
        scl = 1'b0;       qw;
    endtask

    task automatic m_stop;
        m_sda_low = 1'b1; qw;
        scl = 1'b1;       qw;
        m_sda_low = 1'b0; qw; qw;
    endtask

    task automatic m_wbit(input logic b);
        m_sda_low = ~b; qw;
        scl = 1'b1;     qw; qw;
        scl = 1'b0;     qw;
    endtask

    task automatic m_rbit(output logic b);
        m_sda_low = 1'b0; qw;
        scl = 1'b1;       qw;
        #1 b = (sda === 1'b0) ? 1'b0 : 1'b1;
        qw;
        scl = 1'b0;       qw;
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
        m_rbit(ack);
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] d);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            m_rbit(bt);
            d[i] = bt;
        end
        m_wbit(nack);
    endtask

    // Reference: a matching address is ACKed, writes land in rx_data, reads
    // return the host bytes, anything else sees an idle (all-ones) bus.
    function automatic vec_t model(input vec_t v, input logic [7:0] prx, input logic prw);
        vec_t r;
        logic hit, rd;
        r   = v;
        hit = (v.addr[7:1] == 7'h42);
        rd  = v.addr[0];
        r.e_aack  = hit ? 1'b0 : 1'b1;
        r.e_busy  = hit;
        r.e_rw    = hit ? rd : prw;
        r.e_dack  = (hit && v.ack_en) ? 1'b0 : 1'b1;
        r.e_r0    = hit ? v.d0 : 8'hFF;
        r.e_r1    = hit ? v.d1 : 8'hFF;
        r.e_ticks = (hit && !rd) ? v.n : 0;
        r.e_rx    = (hit && !rd) ? ((v.n == 2) ? v.d1 : v.d0) : prx;
        r.e_req   = (hit && rd) ? v.n : 0;
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int b_rx, b_req, b_st, b_sp, b_drv;
        logic a;
        logic [7:0] r;
        b_rx = cnt_rx; b_req = cnt_req; b_st = cnt_start; b_sp = cnt_stop; b_drv = cnt_drv;
        q = v.dvsr;
        rx_ack_en = v.ack_en;
        tx_q.delete();
        tx_q.push_back(v.d0);
        tx_q.push_back(v.d1);
        m_start;
        m_wbyte(v.addr, a);
        chk("addr_ack", a, v.e_aack);
        #1 chk("busy_mid", busy, v.e_busy);
        for (int i = 0; i < v.n; i++) begin
            if (!v.addr[0]) begin
                m_wbyte((i == 0) ? v.d0 : v.d1, a);
                chk("data_ack", a, v.e_dack);
            end else begin
                m_rbyte(i == v.n - 1, r);
                chk("rd_byte", r, (i == 0) ? v.e_r0 : v.e_r1);
            end
        end
        if (v.addr[0]) begin
            #1 chk("sda_released", sda, 1'b1);
        end
        m_stop;
        @(negedge clk);
        chk("rx_data", rx_data, v.e_rx);
        chk("rx_ticks", cnt_rx - b_rx, v.e_ticks);
        chk("tx_reqs", cnt_req - b_req, v.e_req);
        chk("start_ticks", cnt_start - b_st, 1);
        chk("stop_ticks", cnt_stop - b_sp, 1);
        chk("busy_end", busy, 1'b0);
        chk("addr_rw", addr_rw, v.e_rw);
        if (v.e_aack) chk("no_drive", cnt_drv - b_drv, 0);
    endtask

    initial begin
        vec_t v;
        logic a, bt;
        logic [7:0] r, exp_rx;
        logic exp_rw;
        int b_st, b_req;

        //          addr   n  d0     d1     ack  dvsr aack dack r0     r1     rx     tk req busy rw
        tbl[0] = '{8'h84, 1, 8'hA5, 8'h00, 1'b1, 125, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1, 0, 1'b1, 1'b0};
        tbl[1] = '{8'h90, 1, 8'h11, 8'h00, 1'b1, 25,  1'b1, 1'b1, 8'h00, 8'h00, 8'hA5, 0, 0, 1'b0, 1'b0};
        tbl[2] = '{8'h85, 2, 8'h3C, 8'hC3, 1'b1, 25,  1'b0, 1'b0, 8'h3C, 8'hC3, 8'hA5, 0, 2, 1'b1, 1'b1};
        tbl[3] = '{8'h84, 1, 8'h77, 8'h00, 1'b0, 25,  1'b0, 1'b1, 8'h00, 8'h00, 8'h77, 1, 0, 1'b1, 1'b0};
        tbl[4] = '{8'h91, 1, 8'h12, 8'h00, 1'b1, 25,  1'b1, 1'b1, 8'hFF, 8'h00, 8'h77, 0, 0, 1'b0, 1'b0};
        tbl[5] = '{8'h84, 2, 8'h00, 8'hFF, 1'b1, 25,  1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 2, 0, 1'b1, 1'b0};

        repeat (4) @(negedge clk);
        chk("rst_sda", sda, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr_rw", addr_rw, 1'b0);
        chk("rst_ticks", {rx_tick, tx_req, start_tick, stop_tick}, 4'b0000);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        for (int k = 0; k < 6; k++) run_txn(tbl[k]);
        exp_rx = tbl[5].e_rx;
        exp_rw = tbl[5].e_rw;

        for (int k = 0; k < 10; k++) begin
            v.addr   = {($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom_range(0, 127)),
                        1'($urandom_range(0, 1))};
            v.n      = $urandom_range(1, 2);
            v.d0     = 8'($urandom);
            v.d1     = 8'($urandom);
            v.ack_en = 1'($urandom_range(0, 1));
            v.dvsr   = 25;
            v = model(v, exp_rx, exp_rw);
            run_txn(v);
            exp_rx = v.e_rx;
            exp_rw = v.e_rw;
        end

        // Repeated START: write then re-address as a read without a STOP
        q = 25;
        rx_ack_en = 1'b1;
        tx_q.delete();
        tx_q.push_back(8'h5A);
        b_st = cnt_start; b_req = cnt_req;
        m_start;
        m_wbyte(8'h84, a);
        m_wbyte(8'h01, a);
        #1 chk("rs_rw_write", addr_rw, 1'b0);
        m_start;
        m_wbyte(8'h85, a);
        chk("rs_addr_ack", a, 1'b0);
        m_rbyte(1'b1, r);
        chk("rs_rd_byte", r, 8'h5A);
        m_stop;
        @(negedge clk);
        chk("rs_rw_read", addr_rw, 1'b1);
        chk("rs_starts", cnt_start - b_st, 2);
        chk("rs_rx_data", rx_data, 8'h01);
        chk("rs_tx_reqs", cnt_req - b_req, 1);

        // Reset while the target is pulling SDA low during a read byte
        tx_q.delete();
        tx_q.push_back(8'h00);
        m_start;
        m_wbyte(8'h85, a);
        m_rbit(bt);
        m_rbit(bt);
        @(negedge clk);
        chk("pre_rst_drive", sda, 1'b0);
        reset = 1'b1;
        #1 chk("rst_mid_sda", sda, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rx", rx_data, 8'h00);
        chk("rst_mid_rw", addr_rw, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        v.addr = 8'h84; v.n = 1; v.d0 = 8'h3E; v.d1 = 8'h00; v.ack_en = 1'b1; v.dvsr = 25;
        v = model(v, 8'h00, 1'b0);
        run_txn(v);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
